// File: rtl/uart_mmio_if.sv
// ============================================================================
// Module   : uart_mmio_if
// Purpose  : CPU data-memory handshake seen by the UART register block. It is
//            the same addr/ce/we/data/sel/data_o set the RAM wrapper uses.
// Ports    : ce_i    access strobe, one cycle per access
//            we_i    1 = write, 0 = read
//            addr_i  byte address (only [3:2] decoded by the UART)
//            data_i  write data
//            sel_i   byte enables (only [0] honoured by the UART)
//            data_o  read data, combinational from addr_i
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_mmio_if;
  logic        ce_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [3:0]  sel_i;
  logic [31:0] data_o;

  modport master (output ce_i, we_i, addr_i, data_i, sel_i, input data_o);
  modport slave  (input ce_i, we_i, addr_i, data_i, sel_i, output data_o);
endinterface

`default_nettype wire

// File: rtl/uart_mmio.sv
// ============================================================================
// Module   : uart_mmio
// Purpose  : Memory-mapped UART with TX/RX FIFOs, sticky error flags and a
//            level interrupt.
//            Register map by addr_i[3:2]:
//              0 DATA   write pushes TX byte / read pops RX byte
//              1 STATUS {rx_count[15:8], tx_idle, tx_overflow, frame_err,
//                        rx_overrun, rx_avail, tx_ready}; bits 2..4 W1C
//              2 CTRL   {tx_int_en, rx_int_en}
//              3        reads 0, writes ignored
// Ports    : clk    core clock
//            rst_n  asynchronous active-low reset
//            bus    CPU register handshake (slave side)
//            int_o  registered level interrupt
//            txd    serial out, idle high
//            rxd    serial in, asynchronous
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_mmio #(
  parameter int CLK_FREQ   = 25000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  uart_mmio_if.slave   bus,
  output logic         int_o,
  output logic         txd,
  input  wire logic    rxd
);

  localparam int c_DIV   = CLK_FREQ / BAUD;
  localparam int c_CNT_W = $clog2(c_DIV + 1);
  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_FCW   = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(c_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(c_DIV / 2 - 1);
  localparam logic [c_FCW-1:0]   c_FULL      = c_FCW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3} state_t;

  // ---------------- bus decode ----------------
  logic [1:0] w_addr;
  logic       w_wr;
  assign w_addr = bus.addr_i[3:2];
  assign w_wr   = bus.ce_i & bus.we_i & bus.sel_i[0];

  logic w_unused_bits;
  assign w_unused_bits = &{1'b0, bus.addr_i[31:4], bus.addr_i[1:0], bus.data_i[31:8], bus.sel_i[3:1]};

  // ---------------- state declarations ----------------
  logic [7:0]         r_tx_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_tx_wr, r_tx_rd;
  logic [c_FCW-1:0]   r_tx_count;
  logic [7:0]         r_rx_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_rx_wr, r_rx_rd;
  logic [c_FCW-1:0]   r_rx_count;

  state_t             r_tx_state, r_rx_state;
  logic [c_CNT_W-1:0] r_tx_cnt, r_rx_cnt;
  logic [2:0]         r_tx_bit, r_rx_bit;
  logic [7:0]         r_tx_shift, r_rx_shift;
  logic               r_txd, r_rx_s1, r_rx_s2;
  logic               r_rx_overrun, r_frame_err, r_tx_overflow;
  logic [1:0]         r_ctrl;
  logic               r_int;

  // ---------------- FIFO control ----------------
  logic w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic w_tx_push_req, w_tx_push, w_tx_pop, w_tx_drop;
  logic w_rx_pop, w_rx_stop_sample, w_rx_push, w_rx_overrun_set, w_frame_err_set;
  logic w_tx_idle;

  assign w_tx_empty = (r_tx_count == '0);
  assign w_tx_full  = (r_tx_count == c_FULL);
  assign w_rx_empty = (r_rx_count == '0);
  assign w_rx_full  = (r_rx_count == c_FULL);

  // The shifter takes the next byte either from idle or at the last cycle of a
  // stop bit, so back-to-back frames have no idle gap.
  assign w_tx_pop = ~w_tx_empty &
                    ((r_tx_state == S_IDLE) ||
                     (r_tx_state == S_STOP && r_tx_cnt == c_BIT_LAST));
  assign w_tx_push_req = w_wr & (w_addr == 2'd0);
  // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
  assign w_tx_push = w_tx_push_req & (~w_tx_full | w_tx_pop);
  assign w_tx_drop = w_tx_push_req & w_tx_full & ~w_tx_pop;
  assign w_tx_idle = w_tx_empty & (r_tx_state == S_IDLE);

  assign w_rx_pop         = bus.ce_i & ~bus.we_i & (w_addr == 2'd0) & ~w_rx_empty;
  assign w_rx_stop_sample = (r_rx_state == S_STOP) && (r_rx_cnt == c_BIT_LAST);
  assign w_rx_push        = w_rx_stop_sample & r_rx_s2 & (~w_rx_full | w_rx_pop);
  assign w_rx_overrun_set = w_rx_stop_sample & r_rx_s2 & w_rx_full & ~w_rx_pop;
  assign w_frame_err_set  = w_rx_stop_sample & ~r_rx_s2;

  // Storage carries no reset; emptiness is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= bus.data_i[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wr] <= r_rx_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_wr <= '0; r_tx_rd <= '0; r_tx_count <= '0;
      r_rx_wr <= '0; r_rx_rd <= '0; r_rx_count <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
      if (w_tx_push && !w_tx_pop)      r_tx_count <= r_tx_count + 1'b1;
      else if (!w_tx_push && w_tx_pop) r_tx_count <= r_tx_count - 1'b1;
      if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
      if (w_rx_push && !w_rx_pop)      r_rx_count <= r_rx_count + 1'b1;
      else if (!w_rx_push && w_rx_pop) r_rx_count <= r_rx_count - 1'b1;
    end
  end

  // ---------------- TX FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= S_IDLE; r_tx_cnt <= '0; r_tx_bit <= '0;
      r_tx_shift <= '0;     r_txd    <= 1'b1;
    end else begin
      case (r_tx_state)
        S_IDLE: begin
          if (w_tx_pop) begin
            r_tx_shift <= r_tx_mem[r_tx_rd];
            r_tx_cnt   <= '0;
            r_txd      <= 1'b0;
            r_tx_state <= S_START;
          end
        end
        S_START: begin
          if (r_tx_cnt == c_BIT_LAST) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_txd      <= r_tx_shift[0];
            r_tx_state <= S_DATA;
          end else r_tx_cnt <= r_tx_cnt + 1'b1;
        end
        S_DATA: begin
          if (r_tx_cnt == c_BIT_LAST) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 3'd7) begin
              r_txd      <= 1'b1;
              r_tx_state <= S_STOP;
            end else begin
              r_tx_bit   <= r_tx_bit + 1'b1;
              r_tx_shift <= r_tx_shift >> 1;
              r_txd      <= r_tx_shift[1];
            end
          end else r_tx_cnt <= r_tx_cnt + 1'b1;
        end
        S_STOP: begin
          if (r_tx_cnt == c_BIT_LAST) begin
            r_tx_cnt <= '0;
            if (w_tx_pop) begin
              r_tx_shift <= r_tx_mem[r_tx_rd];
              r_txd      <= 1'b0;
              r_tx_state <= S_START;
            end else r_tx_state <= S_IDLE;
          end else r_tx_cnt <= r_tx_cnt + 1'b1;
        end
        default: r_tx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- RX synchronizer + FSM ----------------
  // After the half-bit wait in START every later sample lands mid-bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1 <= 1'b1; r_rx_s2 <= 1'b1;
      r_rx_state <= S_IDLE; r_rx_cnt <= '0; r_rx_bit <= '0; r_rx_shift <= '0;
    end else begin
      r_rx_s1 <= rxd;
      r_rx_s2 <= r_rx_s1;
      case (r_rx_state)
        S_IDLE: begin
          if (!r_rx_s2) begin
            r_rx_cnt   <= '0;
            r_rx_state <= S_START;
          end
        end
        S_START: begin
          if (r_rx_cnt == c_HALF_LAST) begin
            r_rx_cnt <= '0;
            r_rx_bit <= '0;
            r_rx_state <= r_rx_s2 ? S_IDLE : S_DATA;
          end else r_rx_cnt <= r_rx_cnt + 1'b1;
        end
        S_DATA: begin
          if (r_rx_cnt == c_BIT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) r_rx_state <= S_STOP;
            else                  r_rx_bit   <= r_rx_bit + 1'b1;
          end else r_rx_cnt <= r_rx_cnt + 1'b1;
        end
        S_STOP: begin
          if (w_rx_stop_sample) begin
            r_rx_cnt   <= '0;
            r_rx_state <= S_IDLE;
          end else r_rx_cnt <= r_rx_cnt + 1'b1;
        end
        default: r_rx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- control / status ----------------
  logic w_st_wr;
  assign w_st_wr = w_wr & (w_addr == 2'd1);

  // A new error event wins over a simultaneous write-1-to-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_overrun <= 1'b0; r_frame_err <= 1'b0; r_tx_overflow <= 1'b0;
      r_ctrl <= '0; r_int <= 1'b0;
    end else begin
      r_rx_overrun  <= w_rx_overrun_set | (r_rx_overrun  & ~(w_st_wr & bus.data_i[2]));
      r_frame_err   <= w_frame_err_set  | (r_frame_err   & ~(w_st_wr & bus.data_i[3]));
      r_tx_overflow <= w_tx_drop        | (r_tx_overflow & ~(w_st_wr & bus.data_i[4]));
      if (w_wr && w_addr == 2'd2) r_ctrl <= bus.data_i[1:0];
      r_int <= (r_ctrl[0] & ~w_rx_empty) | (r_ctrl[1] & w_tx_idle);
    end
  end

  always_comb begin
    bus.data_o = '0;
    case (w_addr)
      2'd0: if (!w_rx_empty) bus.data_o = {24'b0, r_rx_mem[r_rx_rd]};
      2'd1: bus.data_o = {16'b0, 8'(r_rx_count), 2'b0, w_tx_idle, r_tx_overflow,
                          r_frame_err, r_rx_overrun, ~w_rx_empty, ~w_tx_full};
      2'd2: bus.data_o = {30'b0, r_ctrl};
      default: bus.data_o = '0;
    endcase
  end

  assign int_o = r_int;
  assign txd   = r_txd;

endmodule

`default_nettype wire

// File: tb/tb_uart_mmio.sv
// ============================================================================
// Module   : tb_uart_mmio
// Purpose  : Directed self-checking bench for uart_mmio at DIV = 10.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_mmio;
  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int DIV      = 10;
  localparam int DEPTH    = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rxd = 1'b1;
  logic int_o, txd;
  int   errors = 0;
  int   checks = 0;

  uart_mmio_if bus_if ();

  uart_mmio #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if),
    .int_o(int_o),
    .txd  (txd),
    .rxd  (rxd)
  );

  always #5 clk = ~clk;

  // ---------------- stimulus helpers ----------------
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    bus_if.ce_i = 1'b1; bus_if.we_i = 1'b1;
    bus_if.addr_i = a;  bus_if.data_i = d; bus_if.sel_i = s;
    @(posedge clk); #1;
    bus_if.ce_i = 1'b0; bus_if.we_i = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_if.ce_i = 1'b1; bus_if.we_i = 1'b0; bus_if.addr_i = a;
    #1 d = bus_if.data_o;
    @(posedge clk); #1;
    bus_if.ce_i = 1'b0;
  endtask

  // Combinational look at a register without a strobe (no pop side effect).
  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_if.addr_i = a;
    #1 d = bus_if.data_o;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (DIV) @(negedge clk);
    rxd = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] d;
    bus_if.ce_i = 1'b0; bus_if.we_i = 1'b0; bus_if.addr_i = '0;
    bus_if.data_i = '0; bus_if.sel_i = '0;
    idle(3);
    @(negedge clk) rst_n = 1'b1;
    peek(32'h4, d);
    checks++; if (d !== 32'h21) begin errors++; $display("FAIL reset_status got=%h exp=%h", d, 32'h21); end
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got=%b exp=1", txd); end
    checks++; if (int_o !== 1'b0) begin errors++; $display("FAIL reset_int got=%b exp=0", int_o); end
    peek(32'h8, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl got=%h exp=0", d); end
  endtask

  task automatic test_ctrl();
    logic [31:0] d;
    bus_write(32'h8, 32'h2, 4'h1);
    peek(32'h8, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL ctrl_readback got=%h exp=2", d); end
    idle(2);
    checks++; if (int_o !== 1'b1) begin errors++; $display("FAIL tx_int got=%b exp=1", int_o); end
    bus_write(32'h8, 32'h1, 4'hE);  // sel_i[0]=0: ignored
    peek(32'h8, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL ctrl_sel0 got=%h exp=2", d); end
    bus_write(32'h8, 32'h0, 4'h1);
    idle(2);
    checks++; if (int_o !== 1'b0) begin errors++; $display("FAIL tx_int_off got=%b exp=0", int_o); end
    bus_write(32'hC, 32'hFF, 4'h1);
    peek(32'hC, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reg3 got=%h exp=0", d); end
  endtask

  task automatic test_tx_single();
    logic [7:0]  b = 8'h55;
    logic        exp;
    logic [31:0] d;
    int          bi;
    bus_write(32'h0, 32'h55, 4'h1);
    bus_if.addr_i = 32'h4;
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL tx_pre got=%b exp=1", txd); end
    for (int k = 1; k <= 101; k++) begin
      @(posedge clk); #1;
      bi = (k - 1) / DIV;
      if (bi == 0)      exp = 1'b0;
      else if (bi <= 8) exp = b[bi-1];
      else              exp = 1'b1;
      checks++;
      if (txd !== exp) begin errors++; $display("FAIL tx_bit k=%0d got=%b exp=%b", k, txd, exp); end
      if (k == 100) begin
        d = bus_if.data_o;
        checks++; if (d[5] !== 1'b0) begin errors++; $display("FAIL tx_idle_early got=%b exp=0", d[5]); end
      end
      if (k == 101) begin
        d = bus_if.data_o;
        checks++; if (d !== 32'h21) begin errors++; $display("FAIL tx_done_status got=%h exp=21", d); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int j = 0;
    bus_write(32'h0, 32'h00, 4'h1);
    bus_write(32'h0, 32'hFF, 4'h1);
    bus_write(32'h0, 32'h0F, 4'h1);
    bus_if.addr_i = 32'h4;
    while (j < 400) begin
      @(posedge clk); #1;
      j++;
      if (j == 98)  begin checks++; if (txd !== 1'b1) begin errors++; $display("FAIL b2b_stop1 got=%b exp=1", txd); end end
      if (j == 99)  begin checks++; if (txd !== 1'b0) begin errors++; $display("FAIL b2b_start2 got=%b exp=0", txd); end end
      if (j == 199) begin checks++; if (txd !== 1'b0) begin errors++; $display("FAIL b2b_start3 got=%b exp=0", txd); end end
      if (bus_if.data_o[5]) break;
    end
    checks++;
    if (j != 299) begin errors++; $display("FAIL b2b_idle_cycle got=%0d exp=299", j); end
  endtask

  task automatic test_rx_int();
    logic [31:0] d;
    bus_write(32'h8, 32'h1, 4'h1);
    send_rx(8'hA3, 1'b1);
    idle(2);
    checks++; if (int_o !== 1'b1) begin errors++; $display("FAIL rx_int_rise got=%b exp=1", int_o); end
    peek(32'h4, d);
    checks++; if (d !== 32'h123) begin errors++; $display("FAIL rx_status got=%h exp=123", d); end
    bus_read(32'h0, d);
    checks++; if (d !== 32'hA3) begin errors++; $display("FAIL rx_data got=%h exp=a3", d); end
    idle(2);
    checks++; if (int_o !== 1'b0) begin errors++; $display("FAIL rx_int_fall got=%b exp=0", int_o); end
    peek(32'h4, d);
    checks++; if (d !== 32'h21) begin errors++; $display("FAIL rx_after_pop got=%h exp=21", d); end
    peek(32'h0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rx_empty_read got=%h exp=0", d); end
    bus_write(32'h8, 32'h0, 4'h1);
  endtask

  task automatic test_rx_overrun();
    logic [31:0] d;
    for (int i = 0; i <= DEPTH; i++) send_rx(8'(8'h10 + i), 1'b1);
    idle(2);
    peek(32'h4, d);
    checks++; if (d !== 32'h1027) begin errors++; $display("FAIL ovr_status got=%h exp=1027", d); end
    bus_write(32'h4, 32'h4, 4'h1);
    peek(32'h4, d);
    checks++; if (d !== 32'h1023) begin errors++; $display("FAIL ovr_clear got=%h exp=1023", d); end
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(32'h0, d);
      checks++;
      if (d !== 32'(8'h10 + i)) begin errors++; $display("FAIL ovr_data i=%0d got=%h exp=%h", i, d, 32'(8'h10 + i)); end
    end
    peek(32'h4, d);
    checks++; if (d !== 32'h21) begin errors++; $display("FAIL ovr_drained got=%h exp=21", d); end
  endtask

  task automatic test_frame_err();
    logic [31:0] d;
    send_rx(8'h5A, 1'b0);
    idle(2 * DIV);
    peek(32'h4, d);
    checks++; if (d !== 32'h29) begin errors++; $display("FAIL frame_status got=%h exp=29", d); end
    bus_write(32'h4, 32'h8, 4'h1);
    peek(32'h4, d);
    checks++; if (d !== 32'h21) begin errors++; $display("FAIL frame_clear got=%h exp=21", d); end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    @(negedge clk) rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    idle(20);
    peek(32'h4, d);
    checks++; if (d !== 32'h21) begin errors++; $display("FAIL glitch_status got=%h exp=21", d); end
    send_rx(8'h3C, 1'b1);
    idle(2);
    bus_read(32'h0, d);
    checks++; if (d !== 32'h3C) begin errors++; $display("FAIL glitch_next_byte got=%h exp=3c", d); end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] d;
    for (int i = 0; i < DEPTH + 2; i++) bus_write(32'h0, 32'h00, 4'h1);
    peek(32'h4, d);
    checks++; if (d !== 32'h10) begin errors++; $display("FAIL txovf_status got=%h exp=10", d); end
    bus_write(32'h4, 32'h10, 4'h1);
    peek(32'h4, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL txovf_clear got=%h exp=0", d); end
  endtask

  task automatic test_reset_mid_tx();
    logic [31:0] d;
    idle(20);
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL midtx_pre got=%b exp=0", txd); end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL midtx_async got=%b exp=1", txd); end
    @(negedge clk) rst_n = 1'b1;
    peek(32'h4, d);
    checks++; if (d !== 32'h21) begin errors++; $display("FAIL midtx_status got=%h exp=21", d); end
    idle(5);
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL midtx_quiet got=%b exp=1", txd); end
  endtask

  initial begin
    test_reset();
    test_ctrl();
    test_tx_single();
    test_back_to_back();
    test_rx_int();
    test_rx_overrun();
    test_frame_err();
    test_glitch();
    test_tx_overflow();
    test_reset_mid_tx();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
